mux_stream_rr: RTL
==================

MUX_STREAM_RR -- requirements
Module: mux_stream_rr

Interface
REQ-001 The block SHALL have parameter N_CH, default 8, meaning the number of input channels (2..32).
REQ-002 The block SHALL have parameter W, default 8, meaning the data width per channel.
REQ-003 The block SHALL have parameter MODE, default 0, meaning the arbitration mode: 0 round-robin, 1 fixed priority (lowest index wins).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port in_data  input  N_CH*W  channel i data in bits [i*W +: W].
REQ-007 The block SHALL have port in_valid  input  N_CH  per-channel valid.
REQ-008 The block SHALL have port in_ready  output  N_CH  per-channel ready; at most one bit high per cycle.
REQ-009 The block SHALL have port out_data  output  W  registered selected data.
REQ-010 The block SHALL have port out_valid  output  1  out_data holds an accepted word.
REQ-011 The block SHALL have port out_ready  input  1  downstream accept.
REQ-012 The block SHALL have port out_sel  output  $clog2(N_CH)  index of the channel that supplied out_data.

Function
REQ-013 Transfer on input i SHALL occur when in_valid[i] && in_ready[i] at a rising edge; output transfer when out_valid && out_ready.
REQ-014 load_en SHALL be !out_valid || out_ready; arbitration SHALL grant exactly one valid channel only when load_en is 1.
REQ-015 in_ready[i] SHALL be grant[i] && load_en and SHALL NOT depend combinationally on in_data.
REQ-016 Latency SHALL be 1 cycle: a word accepted at edge k appears on out_data/out_sel with out_valid=1 after edge k.
REQ-017 Throughput SHALL be one word per cycle when out_ready is held high and any in_valid is high.
REQ-018 While out_valid && !out_ready, out_data, out_sel and out_valid SHALL remain stable and all in_ready SHALL be 0.
REQ-019 When load_en is 1 and no in_valid is high, out_valid SHALL go to 0 at the next edge; out_data and out_sel SHALL hold their last values.
REQ-020 MODE 0: a priority pointer p SHALL search channels p, p+1, ..., wrapping modulo N_CH; after a grant to channel g, p SHALL become (g+1) mod N_CH.
REQ-021 MODE 0: p SHALL be unchanged in cycles with no grant; the wrap from N_CH-1 to 0 SHALL be seamless.
REQ-022 MODE 1: the lowest-index valid channel SHALL be granted and the pointer SHALL be unused.
REQ-023 In MODE 0, with all channels continuously valid, every channel SHALL be granted exactly once per N_CH consecutive grants.
REQ-024 If an output drain and a new grant occur in the same cycle, the new word SHALL replace the drained word with no bubble.

Reset
REQ-025 While rst is high, out_valid SHALL be 0, out_data 0, out_sel 0, in_ready all 0 and p 0, regardless of clk.
REQ-026 Reset asserted mid-transfer SHALL discard the held word; after release, the first grant in MODE 0 SHALL start the search at channel 0.

Structure
REQ-027 Package mux_pkg SHALL hold constants MODE_RR=0 and MODE_FIXED=1, and the pointer-width function.
REQ-028 Sub-module rr_arbiter SHALL hold the grant logic and pointer register, parameterised by N_CH and MODE; mux_stream_rr SHALL instantiate it and own the output register.

Verification
REQ-029 N_CH=8, W=8, MODE 0: all in_valid=1, in_data channel i = 8'hA0+i, out_ready=1 -> out_sel sequence 0..7 then 0, out_data A0..A7, one word per cycle.
REQ-030 MODE 0: only channels 2 and 5 valid -> out_sel alternates 2, 5, 2, 5; in_ready never high for any other channel.
REQ-031 out_ready=0 for 4 cycles with out_data=8'h3C held -> out_data, out_sel and out_valid stable, in_ready=0; on out_ready=1 the next word loads in the same cycle.
REQ-032 MODE 1: channels 1, 4 and 7 valid -> channel 1 granted every cycle while valid; 4 granted only after in_valid[1] drops.
REQ-033 rst asserted asynchronously between edges while out_valid=1 -> outputs zero immediately; after release with channels 3 and 0 valid, first out_sel=0.
REQ-034 No valid inputs with out_ready=1 -> out_valid drops after 1 edge and out_data holds its last value.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
package mux_pkg;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;

  // Width of a channel index; at least one bit so two-channel muxes still get a pointer.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Grant logic and priority pointer for the stream multiplexer.
// Grants at most one requesting channel, and only while en is high.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N_CH = 8,
  parameter int unsigned MODE = MODE_RR,
  localparam int unsigned PW  = ptr_width(N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] req,
  output logic [N_CH-1:0] grant,
  output logic [PW-1:0]   grant_idx,
  output logic            grant_any
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  // Search from the pointer (round-robin) or from channel 0 (fixed); first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 0; i < N_CH; i++) begin
      idx = (MODE == MODE_FIXED) ? PW'(i) : PW'((int'(ptr_q) + i) % N_CH);
      if (!found && req[idx]) begin
        found     = 1'b1;
        grant_idx = idx;
      end
    end
    grant_any = found && en;
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer moves just past the granted channel, wrapping to 0 after the last one.
  always_comb begin
    ptr_d = ptr_q;
    if (MODE == MODE_RR && grant_any) begin
      ptr_d = (grant_idx == PW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mux_stream_rr.sv
// N-channel valid/ready stream multiplexer with a one-word registered output stage.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter int unsigned N_CH = 8,
  parameter int unsigned W    = 8,
  parameter int unsigned MODE = MODE_RR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*W-1:0]        in_data,
  input  logic [N_CH-1:0]          in_valid,
  output logic [N_CH-1:0]          in_ready,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N_CH)-1:0]  out_sel
);

  localparam int unsigned PW = ptr_width(N_CH);

  logic          load_en;
  logic          arb_en;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [W-1:0]  data_q;
  logic [PW-1:0] sel_q;
  logic          valid_q;

  // Output register may take a new word when empty or being drained this cycle.
  always_comb begin
    load_en = !valid_q || out_ready;
    // Keep all in_ready low while reset is held, independent of the clock.
    arb_en  = load_en && !rst;
  end

  rr_arbiter #(
    .N_CH (N_CH),
    .MODE (MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .en        (arb_en),
    .req       (in_valid),
    .grant     (in_ready),
    .grant_idx (gnt_idx),
    .grant_any (gnt_any)
  );

  // Output stage: load on grant, go empty on drain without a new word, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else if (gnt_any) begin
      data_q  <= in_data[gnt_idx*W +: W];
      sel_q   <= gnt_idx;
      valid_q <= 1'b1;
    end else if (load_en) begin
      valid_q <= 1'b0;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = valid_q;

endmodule
